// File: rtl/i2s_ser_tx.sv
// I2S serializer: 64-bit stereo words in over valid/ready, bck/lrck/sdata out, bck and lrck derived from clk.
// Optional saturating underrun counter output when I2S_SER_TX_UNDERRUN_CNT_EN is defined.
module i2s_ser_tx #(
   parameter int BCK_DIV = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [63:0] data,
   input  logic        valid,
   output logic        ready,
   output logic        bck,
   output logic        lrck,
   output logic        sdata,
   output logic        frame_start,
   output logic        underrun
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam int DW   = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
   localparam int HALF = BCK_DIV / 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_r;
   logic [DW-1:0] div_r;
   logic [5:0]    k_r;
   logic [63:0]   buf_r;
   logic          buf_full_r;
   logic [63:0]   shift_r;

   logic          accept_s;
   logic          load_s;
   logic          div_last_s;
   logic          buf_full_nxt_s;
   logic [5:0]    bit_sel_s;

   // Handshake, frame-load and bit-select decode.
   always_comb begin
      accept_s       = valid && !buf_full_r;
      load_s         = (state_r == RUN) && en && (div_r == DW'(0)) && (k_r == 6'd0);
      div_last_s     = (div_r == DW'(BCK_DIV - 1));
      // Slot k carries frame bit k-1; modulo-64 makes slot 0 pick the previous frame's last bit.
      bit_sel_s      = 6'd0 - k_r;
      buf_full_nxt_s = buf_full_r;
      if (accept_s) begin
         buf_full_nxt_s = 1'b1;
      end else if (load_s) begin
         buf_full_nxt_s = 1'b0;
      end else begin
         buf_full_nxt_s = buf_full_r;
      end
   end

   // Holding buffer, state machine, bit/slot counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= IDLE;
         div_r       <= DW'(0);
         k_r         <= 6'd0;
         buf_r       <= 64'd0;
         buf_full_r  <= 1'b0;
         shift_r     <= 64'd0;
         ready       <= 1'b1;
         bck         <= 1'b0;
         lrck        <= 1'b0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         if (accept_s) begin
            buf_r <= data;
         end
         buf_full_r <= buf_full_nxt_s;
         ready      <= !buf_full_nxt_s;
         case (state_r)
            IDLE: begin
               div_r   <= DW'(0);
               k_r     <= 6'd0;
               shift_r <= 64'd0;
               bck     <= 1'b0;
               lrck    <= 1'b0;
               sdata   <= 1'b0;
               state_r <= en ? RUN : IDLE;
            end
            RUN: begin
               if (!en) begin
                  state_r <= IDLE;
                  div_r   <= DW'(0);
                  k_r     <= 6'd0;
                  shift_r <= 64'd0;
                  bck     <= 1'b0;
                  lrck    <= 1'b0;
                  sdata   <= 1'b0;
               end else begin
                  bck <= (div_r >= DW'(HALF));
                  if (div_r == DW'(0)) begin
                     lrck  <= k_r[5];
                     sdata <= shift_r[bit_sel_s];
                  end
                  if (load_s) begin
                     shift_r     <= buf_full_r ? buf_r : 64'd0;
                     frame_start <= 1'b1;
                     underrun    <= !buf_full_r;
                  end
                  div_r <= div_last_s ? DW'(0) : div_r + DW'(1);
                  if (div_last_s) begin
                     k_r <= k_r + 6'd1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
   // Saturating count of underrun events; only resetn clears it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         underrun_cnt <= 16'd0;
      end else if (load_s && !buf_full_r && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_ser_tx.sv
// Scoreboard bench for i2s_ser_tx (BCK_DIV=4): expected frames queued at stimulus time, checked per frame.
module tb_i2s_ser_tx;

   localparam int BD = 4;

   logic        clk = 1'b0;
   logic        resetn, en, valid;
   logic [63:0] data;
   logic        ready, bck, lrck, sdata, frame_start, underrun;
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   i2s_ser_tx #(.BCK_DIV(BD)) dut (
      .clk(clk), .resetn(resetn), .en(en), .data(data), .valid(valid),
      .ready(ready), .bck(bck), .lrck(lrck), .sdata(sdata),
      .frame_start(frame_start), .underrun(underrun)
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
      , .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] w;
      bit          u;
      bit          rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   prev_lsb = 1'b0;
   int   ucnt_exp = 0;

   localparam logic [63:0] W1 = 64'hA5A5_0001_8000_0003;
   localparam logic [63:0] W4 = 64'h1234_5678_9ABC_DEF1;
   localparam logic [63:0] W5 = 64'hFEDC_BA98_7654_3211;
   localparam logic [63:0] W6 = 64'h0F0F_F0F0_3C3C_C3C3;
   localparam logic [63:0] W7 = 64'hDEAD_BEEF_CAFE_F00D;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [63:0] w, input bit u, input bit rdy);
      exp_t e;
      e.w = w; e.u = u; e.rdy = rdy;
      exp_q.push_back(e);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_bls"}, {61'd0, bck, lrck, sdata}, 64'd0);
      chk({tag, "_pulses"}, {62'd0, frame_start, underrun}, 64'd0);
   endtask

   // Run one frame from its frame_start; stop_mode 1 drops en, 2 asserts resetn=0 at cycle stop_c.
   task automatic run_frame(input int inj_c, input logic [63:0] w, input int stop_c, input int stop_mode);
      bit          found;
      exp_t        e;
      logic [63:0] got;
      int          bad;
      found = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         if (frame_start === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("fs_wait", 64'(found), 64'd1);
      if (!found) return;
      if (exp_q.size() == 0) begin
         chk("q_empty", 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      if (e.u) ucnt_exp++;
      chk("underrun", 64'(underrun), 64'(e.u));
      chk("ready_at_load", 64'(ready), 64'(e.rdy));
      chk("slot0", 64'(sdata), 64'(prev_lsb));
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
      chk("ucnt", 64'(underrun_cnt), 64'(ucnt_exp));
`endif
      got = 64'd0;
      bad = 0;
      for (int c = 0; c < stop_c; c++) begin
         if (c == inj_c + 1) valid = 1'b0;
         if (bck !== ((c % BD) >= BD / 2)) bad++;
         if (lrck !== (c >= 32 * BD)) bad++;
         if (c > 0 && (frame_start !== 1'b0 || underrun !== 1'b0)) bad++;
         if ((c % BD) == 0 && c >= BD) got[64 - c / BD] = sdata;
         if (c == inj_c) begin
            valid = 1'b1;
            data  = w;
         end
         if (c == stop_c - 1 && stop_c < 64 * BD) begin
            if (stop_mode == 1) en = 1'b0;
            else resetn = 1'b0;
         end
         @(negedge clk);
      end
      valid = 1'b0;
      chk("bck_lrck_seq", 64'(bad), 64'd0);
      if (stop_c == 64 * BD) begin
         chk("word", {got[63:1], 1'b0}, {e.w[63:1], 1'b0});
         prev_lsb = e.w[0];
      end else begin
         prev_lsb = 1'b0;
         chk_quiet("stop");
         chk("stop_ready", 64'(ready), (stop_mode == 1) ? 64'd0 : 64'd1);
         if (stop_mode == 2) begin
            resetn   = 1'b1;
            ucnt_exp = 0;
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
            chk("ucnt_reset", 64'(underrun_cnt), 64'd0);
`endif
         end
      end
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; valid = 1'b0; data = 64'd0;
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst_ready", 64'(ready), 64'd1);
      chk_quiet("rst");
      resetn = 1'b1;
      @(negedge clk);

      // Test 1: buffer a word while idle
      valid = 1'b1; data = W1;
      @(negedge clk);
      valid = 1'b0;
      chk("t1_ready_fall", 64'(ready), 64'd0);
      push_exp(W1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk_quiet("t1_idle");
         @(negedge clk);
      end

      // Test 2: first frame carries W1, next frame underruns with W1's LSB in slot 0
      en = 1'b1;
      run_frame(-1, 64'd0, 64 * BD, 0);
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(-1, 64'd0, 64 * BD, 0);

      // Test 3: sustained underrun
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(-1, 64'd0, 64 * BD, 0);
`ifdef I2S_SER_TX_UNDERRUN_CNT_EN
      chk("t3_ucnt3", 64'(underrun_cnt), 64'd3);
`endif
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(-1, 64'd0, 64 * BD, 0);

      // Test 4: valid on the load cycle -> underrun, word goes out one frame later
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(64 * BD - 1, W4, 64 * BD, 0);
      push_exp(64'd0, 1'b1, 1'b0);
      run_frame(-1, 64'd0, 64 * BD, 0);
      push_exp(W4, 1'b0, 1'b1);
      run_frame(-1, 64'd0, 64 * BD, 0);

      // Test 5: en dropped at slot 40 keeps the buffered word
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(8, W5, 64 * BD, 0);
      push_exp(W5, 1'b0, 1'b1);
      run_frame(8, W6, 40 * BD, 1);
      for (int i = 0; i < 10; i++) begin
         chk_quiet("t5_idle");
         @(negedge clk);
      end
      en = 1'b1;

      // Test 6: reset at slot 20 drops the buffered word; next frame underruns
      push_exp(W6, 1'b0, 1'b1);
      run_frame(8, W7, 20 * BD, 2);
      push_exp(64'd0, 1'b1, 1'b1);
      run_frame(-1, 64'd0, 64 * BD, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
